vga_timing_gen: RTL

Generates 640x480 at 60 Hz VGA raster timing from the 25 MHz pixel clock. Drives DrawX, DrawY and blank into every sprite and background drawing block. Also drives HS and VS to the connector, delayed by a parameterised pipeline so that sync stays aligned with the colour outputs of the ROM-plus-palette pixel path (nominally 2 cycles). Provides frame and line strobes plus a frame counter for animation and game-logic pacing.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_sync_delay.sv | 46 ++++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and coordinate type for the 640x480@60Hz raster.
package vga_timing_pkg;

  localparam int COORD_W     = 10;
  localparam int COORD_LIMIT = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF    = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF    = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START_DEF   = H_VISIBLE_DEF + H_FP_DEF;
  localparam int HS_END_DEF     = HS_START_DEF + H_SYNC_DEF;
  localparam int VS_START_DEF   = V_VISIBLE_DEF + V_FP_DEF;
  localparam int VS_END_DEF     = VS_START_DEF + V_SYNC_DEF;

  // Active-low sync level: low only while pos lies in [start, stop).
  function automatic logic sync_level(input int pos, input int start, input int stop);
    return !((pos >= start) && (pos < stop));
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// WIDTH x DEPTH shift register that keeps sync/blank aligned with the pixel
// colour path; DEPTH = 0 collapses to a wire.
module vga_sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Each stage takes the previous one; stage 0 takes the raw input.
    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Stage registers reset to the idle level so no sync glitch leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, blanking, delayed syncs, strobes
// and a free-running completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIPE_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        Reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        blank_d,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  if ((H_TOTAL > COORD_LIMIT) || (V_TOTAL > COORD_LIMIT)) begin : g_bad_total
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end

  if ((PIPE_DELAY < 0) || (PIPE_DELAY > 8)) begin : g_bad_delay
    $fatal(1, "vga_timing_gen: PIPE_DELAY must be in 0..8");
  end

  coord_t      hc_q, hc_d;
  coord_t      vc_q, vc_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        hs_raw, vs_raw;

  // Advance the raster: pixel every clock, line at end of row, frame tally
  // on the very last pixel so it lands together with the next frame_start.
  always_comb begin
    hc_d          = hc_q + coord_t'(1);
    vc_d          = vc_q;
    frame_count_d = frame_count_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d          = '0;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        vc_d = vc_q + coord_t'(1);
      end
    end
  end

  // Counter registers; reset aborts the frame and restarts at pixel (0,0).
  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      frame_count_q <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Undelayed decode of visible region, raw syncs and strobes.
  always_comb begin
    blank       = (int'(hc_q) < H_VISIBLE) && (int'(vc_q) < V_VISIBLE);
    hs_raw      = sync_level(int'(hc_q), HS_START, HS_END);
    vs_raw      = sync_level(int'(vc_q), VS_START, VS_END);
    line_start  = (hc_q == '0);
    frame_start = (hc_q == '0) && (vc_q == '0);
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_count = frame_count_q;

  vga_sync_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .clk   (vga_clk),
    .rst_n (Reset_n),
    .din   ({hs_raw, vs_raw, blank}),
    .dout  ({hs, vs, blank_d})
  );

endmodule
